pixel_write_queue: RTL and testbench
====================================

# pixel_write_queue

Upstream neighbour of the VGA/SDRAM display interface. Accepts escape-iteration results from `fractal_calc` over a valid/ready handshake and range-checks each pixel coordinate. It converts in-range pixels to linear frame-buffer byte addresses, buffers them in a small FIFO, and drives single-beat writes onto the external SDRAM bridge with an acknowledge handshake. It also reports dropped (out-of-range) pixels and end-of-frame completion.

## Interface
- `FIFO_DEPTH`, 8: FIFO entries; power of two, ≥2.
- `H_RES`, 640: frame width in pixels.
- `V_RES`, 480: frame height in pixels.
- `CLK`  in  1  single clock; all logic on its rising edge.
- `RESET_N`  in  1  reset; asynchronous, active-low.
- `PIX_VALID`  in  1  upstream pixel present.
- `PIX_READY`  out  1  queue can accept; `PIX_READY = (count != FIFO_DEPTH)`.
- `PIX_X`  in  10  pixel column.
- `PIX_Y`  in  9  pixel row.
- `PIX_I`  in  8  iteration count (pixel value).
- `PIX_LAST`  in  1  marks the final pixel of a frame.
- `BR_ADDRESS`  out  19  byte address `PIX_Y*H_RES + PIX_X`.
- `BR_BYTE_EN`  out  2  `2'b01` if address bit 0 = 0, else `2'b10`.
- `BR_WRITE_DATA`  out  16  `{PIX_I, PIX_I}`.
- `BR_WRITE`  out  1  write request.
- `BR_ACK`  in  1  bridge acknowledge.
- `DROP_CNT`  out  16  out-of-range pixels accepted; saturates at 16'hFFFF.
- `FRAME_DONE`  out  1  one-cycle pulse when the `PIX_LAST` entry retires.
- `BUSY`  out  1  FIFO non-empty or write in flight.

## Operation
- **Accept:** a transfer occurs on an edge where `PIX_VALID && PIX_READY`. Every accepted pixel is enqueued in order as `{last, drop, addr[18:0], data[7:0]}`.
- **Drop:** `drop = (PIX_X >= H_RES) || (PIX_Y >= V_RES)`. A dropped entry increments `DROP_CNT` at acceptance and never produces a bus write.
- **Address:** `addr = (PIX_Y<<9) + (PIX_Y<<7) + PIX_X`, computed with 19-bit unsigned arithmetic. Maximum in-range value is 307199.
- **FSM states:**
  - `IDLE`: if the FIFO is non-empty, pop the head.
    - Head with `drop=1`: retire in that cycle and stay in `IDLE`. If `last=1`, pulse `FRAME_DONE` on the next cycle.
    - Head with `drop=0`: register `BR_ADDRESS`, `BR_BYTE_EN`, `BR_WRITE_DATA`, set `BR_WRITE`, and go to `WRITE`.
  - `WRITE`: hold `BR_WRITE` and all `BR_*` outputs stable until `BR_ACK` is sampled high. On that edge, clear `BR_WRITE`, go to `IDLE`, and if the entry had `last=1`, pulse `FRAME_DONE` on the next cycle.
  - `BR_ACK` is ignored in `IDLE`.
- **Simultaneous push and pop:** allowed in the same cycle; `count` is unchanged. When the FIFO is full, `PIX_READY=0`, so no push occurs even if a pop happens in that cycle.
- **FIFO pointers:** wrap modulo `FIFO_DEPTH`. Full/empty are derived from a separate `count` register of width log2(`FIFO_DEPTH`)+1.
- **`BUSY`:** `count != 0 || state == WRITE`.

## Timing
- **Reset (`RESET_N` low, asynchronous):**
  - Outputs: `BR_WRITE=0`, `BR_ADDRESS=0`, `BR_BYTE_EN=0`, `BR_WRITE_DATA=0`, `DROP_CNT=0`, `FRAME_DONE=0`, `BUSY=0`, `PIX_READY=1`.
  - Internal: FSM in `IDLE`, FIFO emptied.
  - A write in flight is abandoned immediately, with no wait for `BR_ACK`.
  - Handshakes presented while reset is low are ignored.
- **Latency:** pixel accepted on edge k with the FIFO empty and FSM in `IDLE` gives `BR_WRITE` high after edge k+1.
- **Back-to-back writes:** `BR_ACK` sampled on edge m gives `BR_WRITE` low after edge m; the next write asserts after edge m+1 at the earliest. There is at least one low cycle between writes, so the sustained maximum is 1 write per 2 cycles with zero-wait ack.
- **Dropped entries:** each retires in 1 cycle.
- **`FRAME_DONE`:** high for exactly one cycle, the cycle after the retiring edge of the `last` entry.
- **Ack longer than one cycle:** `BR_ACK` held high for more than one cycle acknowledges only the current write.

## Test plan
- **Single pixel:** reset, then push (x=3, y=2, I=8'h5A) with `BR_ACK` tied high.
  - `BR_ADDRESS`=1283, `BR_BYTE_EN`=2'b10, `BR_WRITE_DATA`=16'h5A5A.
  - `BR_WRITE` high for exactly 1 cycle, starting 1 cycle after acceptance.
- **Backpressure:** push 12 pixels with `BR_ACK` held low.
  - `PIX_READY` falls after 9 accepts (8 in FIFO plus 1 in flight); `BUSY`=1.
  - Release `BR_ACK`: all 12 writes appear in push order with correct addresses.
- **Drop ordering:** push (639,479), then (640,0), then (0,480) with `PIX_LAST`.
  - One write at address 307199; `DROP_CNT`=2.
  - `FRAME_DONE` pulses once, after the first write's ack.
- **Ack stall:** hold `BR_ACK` low for 20 cycles during a write.
  - `BR_ADDRESS`, `BR_WRITE_DATA`, `BR_BYTE_EN` stable throughout.
  - `BR_WRITE` falls after the ack edge, followed by a minimum 1-cycle gap before the next write.
- **Mid-write reset:** pulse `RESET_N` low during `WRITE` with 4 entries queued.
  - `BR_WRITE` drops asynchronously; `BUSY`=0, `DROP_CNT`=0.
  - No writes after reset release until a new push.
- **Saturation:** force 65,540 out-of-range pushes; `DROP_CNT` holds at 16'hFFFF and `BR_WRITE` never asserts.

Source files
------------

// File: rtl/pixel_write_queue.sv
// pixel_write_queue: range-checks fractal pixels, queues them in a FIFO
// and issues single-beat SDRAM bridge writes with an ack handshake.
module pixel_write_queue #(
    parameter int FIFO_DEPTH = 8,
    parameter int H_RES      = 640,
    parameter int V_RES      = 480
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        PIX_VALID,
    output logic        PIX_READY,
    input  logic [9:0]  PIX_X,
    input  logic [8:0]  PIX_Y,
    input  logic [7:0]  PIX_I,
    input  logic        PIX_LAST,
    output logic [18:0] BR_ADDRESS,
    output logic [1:0]  BR_BYTE_EN,
    output logic [15:0] BR_WRITE_DATA,
    output logic        BR_WRITE,
    input  logic        BR_ACK,
    output logic [15:0] DROP_CNT,
    output logic        FRAME_DONE,
    output logic        BUSY
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef struct packed {
        logic        last;
        logic        drop;
        logic [18:0] addr;
        logic [7:0]  data;
    } entry_t;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t      state_q, state_d;
    entry_t      mem_q [FIFO_DEPTH];
    entry_t      in_entry;
    entry_t      head;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic        push, pop, load, done_d;
    logic        last_q, done_q;
    logic [18:0] addr_q;
    logic [1:0]  be_q;
    logic [15:0] data_q;
    logic [15:0] drop_q, drop_d;
    logic [18:0] y_ext, x_ext;

    assign PIX_READY     = (count_q != FULL_CNT);
    assign push          = PIX_VALID && PIX_READY;
    assign head          = mem_q[rd_ptr_q];
    assign BR_WRITE      = (state_q == WRITE);
    assign BR_ADDRESS    = addr_q;
    assign BR_BYTE_EN    = be_q;
    assign BR_WRITE_DATA = data_q;
    assign DROP_CNT      = drop_q;
    assign FRAME_DONE    = done_q;
    assign BUSY          = (count_q != '0) || (state_q == WRITE);
    assign y_ext         = {10'd0, PIX_Y};
    assign x_ext         = {9'd0, PIX_X};

    // Build the queue entry for the incoming pixel: range check and address.
    always_comb begin
        in_entry      = '0;
        in_entry.last = PIX_LAST;
        in_entry.drop = (PIX_X >= 10'(H_RES)) || (PIX_Y >= 9'(V_RES));
        in_entry.addr = y_ext * 19'(H_RES) + x_ext;
        in_entry.data = PIX_I;
    end

    // FIFO storage; no reset needed since count gates every read.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_entry;
        end
    end

    // Occupancy and saturating drop counter next-state.
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        drop_d = drop_q;
        if (push && in_entry.drop && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 1'b1;
        end
    end

    // FIFO pointers, occupancy and drop counter.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    // Write FSM: pop head, retire drops at once, else hold a bus write to ack.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        load    = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop = 1'b1;
                    if (head.drop) begin
                        done_d = head.last;
                    end else begin
                        load    = 1'b1;
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                if (BR_ACK) begin
                    state_d = IDLE;
                    done_d  = last_q;
                end
            end
        endcase
    end

    // FSM state, bus write registers and frame-done pulse.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            last_q  <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (load) begin
                last_q <= head.last;
                addr_q <= head.addr;
                be_q   <= head.addr[0] ? 2'b10 : 2'b01;
                data_q <= {head.data, head.data};
            end
        end
    end

endmodule

// File: tb/tb_pixel_write_queue.sv
// tb_pixel_write_queue: directed bench with a scoreboard of expected
// bus writes checked by a negedge monitor.
module tb_pixel_write_queue;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        PIX_VALID;
    logic        PIX_READY;
    logic [9:0]  PIX_X;
    logic [8:0]  PIX_Y;
    logic [7:0]  PIX_I;
    logic        PIX_LAST;
    logic [18:0] BR_ADDRESS;
    logic [1:0]  BR_BYTE_EN;
    logic [15:0] BR_WRITE_DATA;
    logic        BR_WRITE;
    logic        BR_ACK;
    logic [15:0] DROP_CNT;
    logic        FRAME_DONE;
    logic        BUSY;

    int ncmp = 0;
    int nerr = 0;
    int nwr  = 0;
    int nfd  = 0;
    logic [36:0] sb [$];
    logic [36:0] hold;
    logic        pw  = 1'b0;
    logic        pfd = 1'b0;

    pixel_write_queue #(.FIFO_DEPTH(8), .H_RES(640), .V_RES(480)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY),
        .PIX_X(PIX_X), .PIX_Y(PIX_Y), .PIX_I(PIX_I), .PIX_LAST(PIX_LAST),
        .BR_ADDRESS(BR_ADDRESS), .BR_BYTE_EN(BR_BYTE_EN),
        .BR_WRITE_DATA(BR_WRITE_DATA), .BR_WRITE(BR_WRITE), .BR_ACK(BR_ACK),
        .DROP_CNT(DROP_CNT), .FRAME_DONE(FRAME_DONE), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input int x, input int y, input int i,
                        input logic last);
        int n = 0;
        logic acc = 1'b0;
        int a;
        PIX_VALID = 1'b1;
        PIX_X = 10'(x);
        PIX_Y = 9'(y);
        PIX_I = 8'(i);
        PIX_LAST = last;
        while (!acc && n < 200) begin
            acc = PIX_READY;
            tick();
            n++;
        end
        PIX_VALID = 1'b0;
        PIX_LAST = 1'b0;
        chk("push_accept", 64'(acc), 64'd1);
        if (acc && x < 640 && y < 480) begin
            a = y * 640 + x;
            sb.push_back({19'(a), (a % 2 == 1) ? 2'b10 : 2'b01,
                          8'(i), 8'(i)});
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((BUSY || sb.size() != 0) && n < 1000) begin
            tick();
            n++;
        end
        chk("idle_busy", 64'(BUSY), 64'd0);
        chk("idle_sb_empty", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: each new write is checked against the scoreboard head.
    always @(negedge CLK) begin
        if (RESET_N) begin
            if (BR_WRITE && !pw) begin
                nwr++;
                if (sb.size() == 0) begin
                    chk("unexpected_write", 64'(BR_WRITE), 64'd0);
                end else begin
                    hold = sb.pop_front();
                    chk("wr_addr", 64'(BR_ADDRESS), 64'(hold[36:18]));
                    chk("wr_be", 64'(BR_BYTE_EN), 64'(hold[17:16]));
                    chk("wr_data", 64'(BR_WRITE_DATA), 64'(hold[15:0]));
                end
            end else if (BR_WRITE && pw) begin
                chk("wr_stable",
                    64'({BR_ADDRESS, BR_BYTE_EN, BR_WRITE_DATA}),
                    64'(hold));
            end
            if (FRAME_DONE) begin
                nfd++;
                chk("frame_done_width", 64'(pfd), 64'd0);
            end
        end
        pw  = BR_WRITE;
        pfd = FRAME_DONE;
    end

    initial begin
        int w0;
        int f0;
        int acc;
        int n;
        RESET_N = 1'b0;
        PIX_VALID = 1'b0;
        PIX_X = '0;
        PIX_Y = '0;
        PIX_I = '0;
        PIX_LAST = 1'b0;
        BR_ACK = 1'b0;
        tick();
        tick();
        chk("rst_write", 64'(BR_WRITE), 64'd0);
        chk("rst_addr", 64'(BR_ADDRESS), 64'd0);
        chk("rst_be", 64'(BR_BYTE_EN), 64'd0);
        chk("rst_data", 64'(BR_WRITE_DATA), 64'd0);
        chk("rst_drop", 64'(DROP_CNT), 64'd0);
        chk("rst_fd", 64'(FRAME_DONE), 64'd0);
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_ready", 64'(PIX_READY), 64'd1);
        RESET_N = 1'b1;
        tick();

        // Single pixel, ack tied high.
        BR_ACK = 1'b1;
        push(3, 2, 8'h5A, 1'b0);
        chk("sp_write_k", 64'(BR_WRITE), 64'd0);
        tick();
        chk("sp_write_k1", 64'(BR_WRITE), 64'd1);
        chk("sp_addr", 64'(BR_ADDRESS), 64'd1283);
        chk("sp_be", 64'(BR_BYTE_EN), 64'd2);
        chk("sp_data", 64'(BR_WRITE_DATA), 64'h5A5A);
        tick();
        chk("sp_write_k2", 64'(BR_WRITE), 64'd0);
        wait_idle();

        // Backpressure: 9 accepts fill FIFO plus one in flight.
        BR_ACK = 1'b0;
        for (int i = 0; i < 9; i++) push(10 + i, 5 + i, 8'h30 + i, 1'b0);
        chk("bp_ready_low", 64'(PIX_READY), 64'd0);
        chk("bp_busy", 64'(BUSY), 64'd1);
        BR_ACK = 1'b1;
        for (int i = 9; i < 12; i++) push(10 + i, 5 + i, 8'h30 + i, 1'b0);
        wait_idle();

        // Drop ordering with frame end on a dropped entry.
        w0 = nwr;
        f0 = nfd;
        push(639, 479, 8'hC3, 1'b0);
        push(640, 0, 8'h01, 1'b0);
        push(0, 480, 8'h02, 1'b1);
        wait_idle();
        tick();
        tick();
        chk("drop_writes", 64'(nwr - w0), 64'd1);
        chk("drop_cnt", 64'(DROP_CNT), 64'd2);
        chk("drop_fd", 64'(nfd - f0), 64'd1);

        // Ack stall for 20 cycles.
        BR_ACK = 1'b0;
        push(100, 50, 8'hAA, 1'b0);
        push(101, 50, 8'hBB, 1'b0);
        for (int i = 0; i < 20; i++) begin
            chk("stall_write", 64'(BR_WRITE), 64'd1);
            tick();
        end
        chk("stall_addr", 64'(BR_ADDRESS), 64'd32100);
        BR_ACK = 1'b1;
        tick();
        chk("stall_gap", 64'(BR_WRITE), 64'd0);
        tick();
        chk("stall_next", 64'(BR_WRITE), 64'd1);
        chk("stall_next_addr", 64'(BR_ADDRESS), 64'd32101);
        wait_idle();

        // Reset during a write with 4 entries queued.
        BR_ACK = 1'b0;
        for (int i = 0; i < 5; i++) push(200 + i, 7, 8'h60 + i, 1'b0);
        chk("mr_write", 64'(BR_WRITE), 64'd1);
        chk("mr_busy", 64'(BUSY), 64'd1);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("mr_write_drop", 64'(BR_WRITE), 64'd0);
        chk("mr_busy_clr", 64'(BUSY), 64'd0);
        chk("mr_drop_clr", 64'(DROP_CNT), 64'd0);
        chk("mr_ready", 64'(PIX_READY), 64'd1);
        sb.delete();
        PIX_VALID = 1'b1;
        PIX_X = 10'd1;
        PIX_Y = 9'd1;
        BR_ACK = 1'b1;
        tick();
        tick();
        tick();
        PIX_VALID = 1'b0;
        RESET_N = 1'b1;
        w0 = nwr;
        for (int i = 0; i < 10; i++) tick();
        chk("mr_no_writes", 64'(nwr - w0), 64'd0);
        chk("mr_busy_after", 64'(BUSY), 64'd0);
        push(4, 0, 8'h77, 1'b0);
        wait_idle();
        chk("mr_new_write", 64'(nwr - w0), 64'd1);

        // Saturation of the drop counter.
        w0 = nwr;
        acc = 0;
        n = 0;
        PIX_X = 10'd700;
        PIX_Y = 9'd0;
        PIX_VALID = 1'b1;
        while (acc < 65540 && n < 70000) begin
            if (PIX_READY) acc++;
            tick();
            n++;
        end
        PIX_VALID = 1'b0;
        tick();
        tick();
        chk("sat_accepts", 64'(acc), 64'd65540);
        chk("sat_drop_cnt", 64'(DROP_CNT), 64'hFFFF);
        chk("sat_no_writes", 64'(nwr - w0), 64'd0);
        chk("sat_busy", 64'(BUSY), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
